// File: rtl/car_pkg.sv
// Shared definitions for the car command path: motion codes, frame bit positions, transmitter states.
// Motion codes are one-hot, and STOP is all-zero. The transmitter maps any other code to STOP.
package car_pkg;

    localparam logic [3:0] MOVE_FORWARD = 4'b0001;
    localparam logic [3:0] MOVE_BACK    = 4'b0010;
    localparam logic [3:0] TURN_LEFT    = 4'b0100;
    localparam logic [3:0] TURN_RIGHT   = 4'b1000;
    localparam logic [3:0] STOP         = 4'b0000;

    localparam int FRM_POWER   = 0;
    localparam int FRM_MOVE_LO = 1;
    localparam int FRM_MOVE_HI = 4;
    localparam int FRM_PLACE   = 5;
    localparam int FRM_DESTROY = 6;
    localparam int FRM_RSVD    = 7;

`ifdef CAR_CMD_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;
`endif

    function automatic logic [3:0] enc_move(input logic [3:0] ms);
        case (ms)
            MOVE_FORWARD, MOVE_BACK, TURN_LEFT, TURN_RIGHT: return ms;
            default:                                        return STOP;
        endcase
    endfunction

endpackage

// File: rtl/car_cmd_tx_baud_gen.sv
// Bit-period timer for the command UART: tick pulses once every CLK_HZ/BAUD cycles while en is high.
// Latency: first tick BIT_CYC cycles after en rises. When en is low, the counter is cleared and held.
// Backpressure: none.
module baud_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/car_cmd_tx.sv
// UART command transmitter toward the car simulator; CAR_CMD_TX_PARITY_EN adds an even-parity bit.
// Latency: the start bit goes out on the edge after launch. A frame takes 10 bit periods, or 11 with parity.
// Backpressure: none. Inputs are evaluated only in IDLE. Beacon edges are held in pend flags until a frame carries them.
module car_cmd_tx
    import car_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int REFRESH_CYC = 2_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [3:0] moving_state,
    input  logic       pl_beacon_sig,
    input  logic       de_beacon_sig,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYC - 1);

    tx_state_t     state;
    logic [7:0]    tx_byte;
    logic [2:0]    bit_idx;
    logic [4:0]    last_cmd;
    logic [RW-1:0] refresh_cnt;
    logic          pl_q, de_q, pl_pend, de_pend;
    logic          bit_tick;
    logic [4:0]    cur_cmd;
    logic          pl_rise, de_rise, launch;

    assign cur_cmd = {enc_move(moving_state), power};
    assign pl_rise = pl_beacon_sig & ~pl_q;
    assign de_rise = de_beacon_sig & ~de_q;
    assign launch  = (cur_cmd != last_cmd) || pl_pend || de_pend || (refresh_cnt == REFRESH_MAX);

    baud_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud (
        .sys_clk (sys_clk),
        .rst     (rst),
        .en      (state != ST_IDLE),
        .tick    (bit_tick)
    );

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            tx_byte     <= '0;
            bit_idx     <= '0;
            last_cmd    <= '0;
            refresh_cnt <= '0;
            pl_q        <= 1'b0;
            de_q        <= 1'b0;
            pl_pend     <= 1'b0;
            de_pend     <= 1'b0;
        end else begin
            pl_q       <= pl_beacon_sig;
            de_q       <= de_beacon_sig;
            pl_pend    <= pl_pend | pl_rise;
            de_pend    <= de_pend | de_rise;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        // An edge arriving in the capture cycle is included here, not left pending.
                        tx_byte     <= {1'b0, de_pend | de_rise, pl_pend | pl_rise, cur_cmd};
                        last_cmd    <= cur_cmd;
                        pl_pend     <= 1'b0;
                        de_pend     <= 1'b0;
                        refresh_cnt <= '0;
                        bit_idx     <= '0;
                        tx          <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_START;
                    end else if (refresh_cnt != REFRESH_MAX) begin
                        refresh_cnt <= refresh_cnt + RW'(1);
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx    <= tx_byte[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef CAR_CMD_TX_PARITY_EN
                            tx    <= ^tx_byte;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= tx_byte[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef CAR_CMD_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_car_cmd_tx.sv
// Bench for car_cmd_tx at 10 cycles per bit with a 50-cycle refresh. The expected bytes are queued as stimulus is applied.
module tb_car_cmd_tx;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       power   = 1'b0;
    logic [3:0] ms      = 4'b0000;
    logic       pl      = 1'b0;
    logic       de      = 1'b0;
    logic       tx, busy, frame_done;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

`ifdef CAR_CMD_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int WAIT_MAX = 300;

    always #5 sys_clk = ~sys_clk;

    car_cmd_tx #(
        .CLK_HZ      (1000),
        .BAUD        (100),
        .REFRESH_CYC (50)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .power         (power),
        .moving_state  (ms),
        .pl_beacon_sig (pl),
        .de_beacon_sig (de),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts the falling edges until tx is first sampled low.
    task automatic wait_start(output int t);
        t = 0;
        do begin
            @(negedge sys_clk);
            t++;
        end while (tx !== 1'b0 && t < WAIT_MAX);
    endtask

    task automatic rx_frame(input string tag, input int exp_wait);
        int         t;
        logic [7:0] b;
        logic [7:0] e;
        wait_start(t);
        chk({tag, "_latency"}, t, exp_wait);
        if (t >= WAIT_MAX) return;
        chk({tag, "_sb"}, exp_q.size() != 0, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        repeat (5) @(negedge sys_clk);
        chk({tag, "_start"}, {busy, tx}, 2'b10);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge sys_clk);
            b[i] = tx;
        end
`ifdef CAR_CMD_TX_PARITY_EN
        repeat (10) @(negedge sys_clk);
        chk({tag, "_parity"}, tx, ^e);
`endif
        repeat (10) @(negedge sys_clk);
        chk({tag, "_stop"}, tx, 1);
        repeat (4) @(negedge sys_clk);
        chk({tag, "_busy_end"}, {busy, frame_done}, 2'b10);
        @(negedge sys_clk);
        chk({tag, "_done"}, {busy, frame_done}, 2'b01);
        chk({tag, "_byte"}, b, e);
    endtask

    initial begin
        int t;
        #2 rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);

        // First frame after reset, followed by a refresh of the unchanged command.
        power = 1'b1;
        ms    = 4'b0001;
        exp_q.push_back(8'h03);
        rst = 1'b1;
        rx_frame("first", 1);
        exp_q.push_back(8'h03);
        rx_frame("refresh", 50);

        // A place pulse mid-frame leaves the frame in flight unchanged and goes out in the next frame.
        exp_q.push_back(8'h03);
        fork
            rx_frame("refresh2", 50);
            begin
                repeat (100) @(negedge sys_clk);
                pl = 1'b1;
                @(negedge sys_clk);
                pl = 1'b0;
            end
        join
        exp_q.push_back(8'h23);
        rx_frame("beacon", 1);
        exp_q.push_back(8'h03);
        rx_frame("after_beacon", 50);

        // A non-one-hot motion code encodes as STOP. Both beacons go out together, and held levels do not retrigger.
        ms = 4'b0110;
        exp_q.push_back(8'h01);
        fork
            rx_frame("invalid_ms", 1);
            begin
                repeat (60) @(negedge sys_clk);
                pl = 1'b1;
                de = 1'b1;
            end
        join
        exp_q.push_back(8'h61);
        rx_frame("both_beacons", 1);
        exp_q.push_back(8'h01);
        fork
            rx_frame("level_hold", 50);
            begin
                repeat (70) @(negedge sys_clk);
                pl = 1'b0;
                de = 1'b0;
            end
        join
        ms = 4'b0100;
        exp_q.push_back(8'h09);
        rx_frame("left", 1);

        // Reset during data bit 3 of 0x11 aborts the frame and drops a pending place request.
        ms = 4'b1000;
        wait_start(t);
        chk("abort_latency", t, 1);
        repeat (5) @(negedge sys_clk);
        pl = 1'b1;
        @(negedge sys_clk);
        pl = 1'b0;
        repeat (39) @(negedge sys_clk);
        rst = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        power = 1'b0;
        ms    = 4'b0000;
        repeat (3) @(negedge sys_clk);
        rst = 1'b1;
        exp_q.push_back(8'h00);
        rx_frame("post_reset", 50);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
